regfile_seq_ctrl: RTL and testbench
===================================

# regfile_seq_ctrl

Multi-cycle sequencer for the 16-bit register-file datapath. It fetches a 16-bit instruction through a request/acknowledge port, decodes it into register-file controls (`rs`, `rt`, `rd`, `opcode`, `w_en`, `w_en2`) and starts the ALU. It also runs RAM load/store handshakes. It sits between instruction memory, the register file, the ALU and data RAM, and it is the only source of register-file write enables.

## Interface
- `PC_W`, default 8: program-counter width; wraps modulo 2^PC_W.
- `TIMEOUT`, default 16: maximum wait cycles on any acknowledge before error.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `pc` out PC_W: address of the current instruction.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: fetch acknowledge; `instr` is valid in the same cycle.
- `instr` in 16: instruction word.
- `rs`, `rt`, `rd` out 3 each: register-file read and write selects.
- `opcode` out 4: opcode presented to the register file.
- `w_en` out 1: register-file write strobe.
- `w_en2` out 1: register-file read-for-store enable.
- `wb_sel` out 1: write-back source select; 0 = ALU, 1 = RAM.
- `alu_start` out 1: single-cycle ALU start pulse.
- `alu_done` in 1: ALU result valid.
- `mem_req` out 1: data RAM request.
- `mem_we` out 1: data RAM write; qualifies `mem_req`.
- `mem_ack` in 1: data RAM acknowledge.
- `halted` out 1: sequencer stopped.
- `err` out 1: sticky timeout error.
- `state_dbg` out 3: current state encoding.

## Operation
- **Instruction format:** `instr[15:12]` = opcode, `[11:9]` = rd, `[8:6]` = rs, `[5:3]` = rt, `[2:0]` ignored.
- **States and encodings:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- **FETCH:** `imem_req`=1.
  - When `imem_ack`=1, latch `instr` into the instruction register and go to DECODE.
- **DECODE:** one cycle; `rs`/`rt`/`rd` are driven from the instruction register from this state onward.
  - Opcode 15 → HALT.
  - Opcodes 13 and 14 → MEM.
  - All others → EXEC.
- **EXEC:** `alu_start`=1 on the first EXEC cycle only; then wait for `alu_done`.
  - Opcodes 0–9 → WB.
  - Opcodes 10–12 (HI/LO moves, written by the register file itself) → FETCH with `pc` incremented. `w_en` stays 0.
- **MEM, opcode 13 (load):** `mem_req`=1, `mem_we`=0.
  - On `mem_ack` → WB with `wb_sel`=1.
- **MEM, opcode 14 (store):** `mem_req`=1, `mem_we`=1, `w_en2`=1 for the whole state.
  - On `mem_ack` → FETCH with `pc`+1.
- **WB:** `w_en`=1 for exactly one cycle, then → FETCH with `pc`+1.
  - `wb_sel`=1 only for loads; 0 otherwise.
- **`opcode` output:** carries the latched opcode only in EXEC and WB; it is 4'h0 in every other state. This prevents spurious HI/LO writes during fetch.
- **HALT:** all request and strobe outputs are 0 and `halted`=1. Only `rst` exits HALT.
- **Timeout:** a wait counter clears on every state entry and counts the cycles spent in FETCH, EXEC or MEM without the awaited acknowledge.
  - When it reaches `TIMEOUT`, set `err`=1 and go to HALT.
  - `err` is cleared only by `rst`.
- **PC arithmetic:** unsigned increment modulo 2^PC_W; PC_W=8 gives 255 → 0.
- **Spurious acknowledges:** acks arriving outside their own state are ignored.
  - `alu_done` in the same cycle as `alu_start` counts as done.

## Timing
- **Reset values:** while `rst`=1 at a rising edge, state=FETCH, `pc`=0 and the instruction register=0. Every output is 0, `err`=0 and `halted`=0.
  - Reset mid-transaction abandons the transaction with no write.
  - `imem_req` rises in the first cycle after `rst` deasserts.
- **Output style:** all outputs are Moore outputs decoded from registered state and registers; there is no combinational path from any input to any output.
- **Minimum latencies with zero-wait acknowledges:**
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 4 cycles (FETCH, DECODE, MEM, WB).
  - Store: 3 cycles.
  - HI/LO move: 3 cycles.
- **Timeout detection:** an ack arriving on wait cycle `TIMEOUT`-1 is accepted. No ack by wait cycle `TIMEOUT` enters HALT on the following edge.
- **Request stability:** `imem_req` and `mem_req` hold steady until acknowledged. They drop in the cycle after the ack edge.

## Test plan
- **Reset then ADD:** reset, then `instr`=0x0A50 (op0, rd5, rs1, rt2) with `imem_ack` the same cycle and `alu_done` the same cycle as start.
  - Expect `w_en`=1 in cycle 4 with `rd`=5, `opcode`=0.
  - Expect `pc`=1 when FETCH is re-entered.
- **Load with 3-cycle `mem_ack` delay:** `instr`=0xD200.
  - Expect `mem_req`=1, `mem_we`=0 for 3 cycles.
  - Expect WB with `wb_sel`=1, `w_en`=1, `rd`=1.
- **Store:** `instr`=0xE600.
  - Expect `w_en2`=1 and `mem_we`=1 throughout MEM, with `rd`=3.
  - Expect `w_en` never asserted.
- **HI/LO move:** `instr`=0xA000.
  - Expect `opcode`=10 only during EXEC, `w_en`=0 and `pc`+1.
  - Expect `opcode`=0 during FETCH and DECODE.
- **Timeout and halt:** hold `alu_done`=0 with TIMEOUT=16.
  - Expect `err`=1, `halted`=1 and `state_dbg`=5 after 16 EXEC wait cycles.
  - Expect outputs frozen at 0.
  - Expect `rst` to restore `pc`=0, `err`=0.
- **Wrap and reset mid-operation:**
  - Preload `pc`=255 via 255 HI/LO moves; a further move gives `pc`=0.
  - Assert `rst` during MEM with `mem_ack` pending: expect `mem_req`=0 next cycle and no `w_en` pulse.

Source files
------------

// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: multi-cycle sequencer for the 16-bit register-file datapath.
// Fetches an instruction over a req/ack port, decodes it into register-file
// selects and strobes, starts the ALU, runs RAM load/store handshakes and
// halts with a sticky error if any awaited acknowledge takes too long.
module regfile_seq_ctrl #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [PC_W-1:0] pc_o,
    output logic            imem_req_o,
    input  logic            imem_ack_i,
    input  logic [15:0]     instr_i,
    output logic [2:0]      rs_o,
    output logic [2:0]      rt_o,
    output logic [2:0]      rd_o,
    output logic [3:0]      opcode_o,
    output logic            w_en_o,
    output logic            w_en2_o,
    output logic            wb_sel_o,
    output logic            alu_start_o,
    input  logic            alu_done_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    input  logic            mem_ack_i,
    output logic            halted_o,
    output logic            err_o,
    output logic [2:0]      state_dbg_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_LAST_WB = 4'd9;
    localparam logic [3:0] OP_LOAD    = 4'd13;
    localparam logic [3:0] OP_STORE   = 4'd14;
    localparam logic [3:0] OP_HALT    = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:3]       instrReg_q, instrReg_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              err_q, err_d;
    // High for the first cycle after reset so the fetch request only rises
    // once reset has actually been released.
    logic              resetHold_q;

    logic [3:0] irOp;
    logic       isLoad;
    logic       isStore;
    logic       waitExpired;
    logic       unusedLowBits;

    assign irOp          = instrReg_q[15:12];
    assign isLoad        = (irOp == OP_LOAD);
    assign isStore       = (irOp == OP_STORE);
    assign waitExpired   = (waitCnt_q == WAIT_LAST);
    assign unusedLowBits = ^instr_i[2:0];

    // State, PC, instruction register, wait counter and error flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            instrReg_q  <= '0;
            waitCnt_q   <= '0;
            err_q       <= 1'b0;
            resetHold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instrReg_q  <= instrReg_d;
            waitCnt_q   <= waitCnt_d;
            err_q       <= err_d;
            resetHold_q <= 1'b0;
        end
    end

    // Next-state logic: handshakes advance the sequence, waits time out to HALT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instrReg_d = instrReg_q;
        waitCnt_d  = waitCnt_q;
        err_d      = err_q;

        case (state_q)
            S_FETCH: begin
                if (!resetHold_q) begin
                    if (imem_ack_i) begin
                        instrReg_d = instr_i[15:3];
                        state_d    = S_DECODE;
                        waitCnt_d  = '0;
                    end else if (waitExpired) begin
                        err_d     = 1'b1;
                        state_d   = S_HALT;
                        waitCnt_d = '0;
                    end else begin
                        waitCnt_d = waitCnt_q + WAIT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                waitCnt_d = '0;
                if (irOp == OP_HALT) begin
                    state_d = S_HALT;
                end else if (isLoad || isStore) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (alu_done_i) begin
                    waitCnt_d = '0;
                    if (irOp <= OP_LAST_WB) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + PC_W'(1);
                    end
                end else if (waitExpired) begin
                    err_d     = 1'b1;
                    state_d   = S_HALT;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    waitCnt_d = '0;
                    if (isLoad) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + PC_W'(1);
                    end
                end else if (waitExpired) begin
                    err_d     = 1'b1;
                    state_d   = S_HALT;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                waitCnt_d = '0;
                state_d   = S_FETCH;
                pc_d      = pc_q + PC_W'(1);
            end
            S_HALT: begin
                waitCnt_d = '0;
            end
            default: begin
                state_d   = S_FETCH;
                waitCnt_d = '0;
            end
        endcase
    end

    // Moore output decode from the registered state and instruction register.
    always_comb begin
        imem_req_o  = 1'b0;
        rs_o        = 3'd0;
        rt_o        = 3'd0;
        rd_o        = 3'd0;
        opcode_o    = 4'h0;
        w_en_o      = 1'b0;
        w_en2_o     = 1'b0;
        wb_sel_o    = 1'b0;
        alu_start_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        halted_o    = 1'b0;

        if (state_q != S_FETCH) begin
            rd_o = instrReg_q[11:9];
            rs_o = instrReg_q[8:6];
            rt_o = instrReg_q[5:3];
        end

        case (state_q)
            S_FETCH: begin
                imem_req_o = !resetHold_q;
            end
            S_EXEC: begin
                opcode_o    = irOp;
                alu_start_o = (waitCnt_q == '0);
            end
            S_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = isStore;
                w_en2_o   = isStore;
            end
            S_WB: begin
                opcode_o = irOp;
                w_en_o   = 1'b1;
                wb_sel_o = isLoad;
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                imem_req_o = 1'b0;
            end
        endcase
    end

    assign pc_o        = pc_q;
    assign err_o       = err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb_regfile_seq_ctrl: directed and randomized bench for regfile_seq_ctrl.
// A transaction-level model predicts the per-cycle outputs of each
// instruction from its opcode and the chosen acknowledge delays.
module tb_regfile_seq_ctrl;

    localparam int PC_W    = 8;
    localparam int TIMEOUT = 16;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef struct packed {
        logic            imemReq;
        logic [2:0]      rs;
        logic [2:0]      rt;
        logic [2:0]      rd;
        logic [3:0]      opcode;
        logic            wEn;
        logic            wEn2;
        logic            wbSel;
        logic            aluStart;
        logic            memReq;
        logic            memWe;
        logic            halted;
        logic            err;
        logic [2:0]      stateDbg;
        logic [PC_W-1:0] pc;
    } outVec_t;

    logic            clock = 1'b0;
    logic            rstIn = 1'b1;
    logic            imemAck = 1'b0;
    logic [15:0]     instrIn = 16'h0;
    logic            aluDone = 1'b0;
    logic            memAck = 1'b0;
    logic [PC_W-1:0] pcObs;
    logic            imemReqObs;
    logic [2:0]      rsObs, rtObs, rdObs;
    logic [3:0]      opcodeObs;
    logic            wEnObs, wEn2Obs, wbSelObs, aluStartObs;
    logic            memReqObs, memWeObs, haltedObs, errObs;
    logic [2:0]      stateObs;
    outVec_t         obsVec;

    int checks = 0;
    int errors = 0;
    int pcModel = 0;
    logic errModel = 1'b0;

    outVec_t fullMask;
    outVec_t selMask;

    regfile_seq_ctrl #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i      (clock),
        .rst_i      (rstIn),
        .pc_o       (pcObs),
        .imem_req_o (imemReqObs),
        .imem_ack_i (imemAck),
        .instr_i    (instrIn),
        .rs_o       (rsObs),
        .rt_o       (rtObs),
        .rd_o       (rdObs),
        .opcode_o   (opcodeObs),
        .w_en_o     (wEnObs),
        .w_en2_o    (wEn2Obs),
        .wb_sel_o   (wbSelObs),
        .alu_start_o(aluStartObs),
        .alu_done_i (aluDone),
        .mem_req_o  (memReqObs),
        .mem_we_o   (memWeObs),
        .mem_ack_i  (memAck),
        .halted_o   (haltedObs),
        .err_o      (errObs),
        .state_dbg_o(stateObs)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Gather every DUT output into one vector for whole-cycle comparison.
    always_comb begin
        obsVec = {imemReqObs, rsObs, rtObs, rdObs, opcodeObs, wEnObs, wEn2Obs,
                  wbSelObs, aluStartObs, memReqObs, memWeObs, haltedObs,
                  errObs, stateObs, pcObs};
    end

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic iAck, input logic [15:0] ins,
                                 input logic aDone, input logic mAck);
        imemAck = iAck;
        instrIn = ins;
        aluDone = aDone;
        memAck  = mAck;
    endtask

    task automatic checkOutput(input string tag, input outVec_t exp, input outVec_t mask);
        checks++;
        assert ((obsVec & mask) === (exp & mask))
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h required %h (pc model %0d)",
                   tag, obsVec & mask, exp & mask, pcModel);
        end
    endtask

    function automatic outVec_t baseExp(input logic [2:0] st);
        outVec_t e;
        e          = '0;
        e.stateDbg = st;
        e.pc       = PC_W'(pcModel);
        e.err      = errModel;
        return e;
    endfunction

    function automatic outVec_t withFields(input outVec_t eIn, input logic [15:0] ins);
        outVec_t e;
        e    = eIn;
        e.rd = ins[11:9];
        e.rs = ins[8:6];
        e.rt = ins[5:3];
        return e;
    endfunction

    task automatic applyReset();
        rstIn = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        stepCycle();
        pcModel  = 0;
        errModel = 1'b0;
        checkOutput("reset", '0, fullMask);
        rstIn = 1'b0;
        stepCycle();
    endtask

    task automatic enterHalt(input string tag);
        outVec_t e;
        e        = baseExp(ST_HALT);
        e.halted = 1'b1;
        checkOutput(tag, e, selMask);
    endtask

    task automatic holdHalt(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            stepCycle();
            enterHalt("haltHold");
        end
    endtask

    // One instruction: df/dx are the fetch and exec/mem ack delays in cycles
    // (a delay of TIMEOUT or more means the ack never comes); abortAt >= 0
    // asserts reset in that MEM cycle with mem_ack pending.
    task automatic execInstr(input logic [15:0] ins, input int df, input int dx,
                             input int abortAt);
        logic [3:0] op;
        outVec_t    e;
        op = ins[15:12];

        for (int k = 0; k <= df && k < TIMEOUT; k++) begin
            e         = baseExp(ST_FETCH);
            e.imemReq = 1'b1;
            checkOutput("fetch", e, selMask);
            applyStimulus(k == df, (k == df) ? ins : 16'($urandom),
                          1'($urandom), 1'($urandom));
            stepCycle();
        end
        if (df >= TIMEOUT) begin
            errModel = 1'b1;
            enterHalt("fetchTimeoutHalt");
            return;
        end

        e = withFields(baseExp(ST_DECODE), ins);
        checkOutput("decode", e, fullMask);
        applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        stepCycle();

        if (op == 4'd15) begin
            enterHalt("haltOpcode");
            return;
        end

        if (op == 4'd13 || op == 4'd14) begin
            for (int k = 0; k <= dx && k < TIMEOUT; k++) begin
                e        = withFields(baseExp(ST_MEM), ins);
                e.memReq = 1'b1;
                e.memWe  = (op == 4'd14);
                e.wEn2   = (op == 4'd14);
                checkOutput(op == 4'd13 ? "memLoad" : "memStore", e, fullMask);
                if (k == abortAt) begin
                    rstIn = 1'b1;
                    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
                    stepCycle();
                    pcModel  = 0;
                    errModel = 1'b0;
                    checkOutput("rstMidMem", '0, fullMask);
                    rstIn = 1'b0;
                    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
                    stepCycle();
                    return;
                end
                applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), k == dx);
                stepCycle();
            end
            if (dx >= TIMEOUT) begin
                errModel = 1'b1;
                enterHalt("memTimeoutHalt");
                return;
            end
            if (op == 4'd13) begin
                e        = withFields(baseExp(ST_WB), ins);
                e.opcode = op;
                e.wEn    = 1'b1;
                e.wbSel  = 1'b1;
                checkOutput("wbLoad", e, fullMask);
                applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                stepCycle();
            end
        end else begin
            for (int k = 0; k <= dx && k < TIMEOUT; k++) begin
                e          = withFields(baseExp(ST_EXEC), ins);
                e.opcode   = op;
                e.aluStart = (k == 0);
                checkOutput("exec", e, fullMask);
                applyStimulus(1'($urandom), 16'($urandom), k == dx, 1'($urandom));
                stepCycle();
            end
            if (dx >= TIMEOUT) begin
                errModel = 1'b1;
                enterHalt("execTimeoutHalt");
                return;
            end
            if (op <= 4'd9) begin
                e        = withFields(baseExp(ST_WB), ins);
                e.opcode = op;
                e.wEn    = 1'b1;
                checkOutput("wbAlu", e, fullMask);
                applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                stepCycle();
            end
        end
        pcModel = (pcModel + 1) % (1 << PC_W);
    endtask

    // Directed scenarios, randomized traffic, timeouts, wrap and mid-op reset.
    initial begin
        logic [15:0] ins;
        int          df;
        int          dx;

        fullMask    = '1;
        selMask     = '1;
        selMask.rs  = 3'd0;
        selMask.rt  = 3'd0;
        selMask.rd  = 3'd0;

        applyReset();

        execInstr(16'h0A50, 0, 0, -1);
        execInstr(16'hD200, 0, 2, -1);
        execInstr(16'hE600, 0, 0, -1);
        execInstr(16'hE600, 1, 3, -1);
        execInstr(16'hA000, 0, 0, -1);
        execInstr(16'h3A48, TIMEOUT - 1, TIMEOUT - 1, -1);
        execInstr(16'hD7F8, 2, TIMEOUT - 1, -1);
        execInstr(16'hC123, 0, 1, -1);

        for (int n = 0; n < 150; n++) begin
            ins        = 16'($urandom);
            ins[15:12] = 4'($urandom_range(0, 14));
            df = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            dx = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            execInstr(ins, df, dx, -1);
        end

        execInstr(16'h0A50, 0, TIMEOUT, -1);
        holdHalt(4);
        applyReset();

        execInstr(16'h0000, TIMEOUT, 0, -1);
        holdHalt(3);
        applyReset();

        execInstr(16'hE600, 0, TIMEOUT, -1);
        holdHalt(2);
        applyReset();

        execInstr(16'hF000, 0, 0, -1);
        holdHalt(5);
        applyReset();

        for (int n = 0; n < 256; n++) begin
            ins        = 16'($urandom);
            ins[15:12] = 4'($urandom_range(10, 12));
            execInstr(ins, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), -1);
        end
        execInstr(16'h0A50, 0, 0, -1);

        execInstr(16'hD200, 0, 5, 1);
        execInstr(16'h0A50, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
